// File: rtl/alu_arbitro_rr.sv
// Round-robin arbiter that shares one ALU among NREQ requesters: grant, drive the ALU for one
// cycle, capture result and flags, and return them tagged with the requester index.
module alu_arbitro_rr #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*4-1:0]     req_op,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_result,
  output logic                  resp_zero,
  output logic                  resp_carry,
  output logic                  resp_overflow,
  output logic                  resp_err,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [3:0]            alu_control,
  input  logic [WIDTH-1:0]      alu_resultado,
  input  logic                  alu_zero,
  input  logic                  alu_carry_out,
  input  logic                  alu_overflow
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [3:0]        op_q, op_d;
  logic [IDW-1:0]    resp_id_q, resp_id_d;
  logic [WIDTH-1:0]  resp_result_q, resp_result_d;
  logic              resp_zero_q, resp_zero_d;
  logic              resp_carry_q, resp_carry_d;
  logic              resp_ovf_q, resp_ovf_d;
  logic              resp_err_q, resp_err_d;

  logic              grant_found;
  logic [IDW-1:0]    grant_id;
  logic [IDW:0]      idx;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Cyclic search starting at ptr; idx is one bit wider so ptr+k never overflows before the wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) begin
        idx = idx - (IDW+1)'(NREQ);
      end
      if (!grant_found && req_valid[idx[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    resp_carry_d  = resp_carry_q;
    resp_ovf_d    = resp_ovf_q;
    resp_err_d    = resp_err_q;
    req_ready     = '0;

    case (state_q)
      StIdle: begin
        if (grant_found) begin
          req_ready[grant_id] = 1'b1;
          id_d    = grant_id;
          a_d     = req_a[grant_id*WIDTH +: WIDTH];
          b_d     = req_b[grant_id*WIDTH +: WIDTH];
          op_d    = req_op[grant_id*4 +: 4];
          state_d = StExec;
        end
      end
      StExec: begin
        resp_id_d = id_q;
        if (op_legal(op_q)) begin
          resp_result_d = alu_resultado;
          resp_zero_d   = alu_zero;
          resp_carry_d  = alu_carry_out;
          resp_ovf_d    = alu_overflow;
          resp_err_d    = 1'b0;
        end else begin
          resp_result_d = '0;
          resp_zero_d   = 1'b0;
          resp_carry_d  = 1'b0;
          resp_ovf_d    = 1'b0;
          resp_err_d    = 1'b1;
        end
        state_d = StResp;
      end
      StResp: begin
        if (resp_ready) begin
          ptr_d   = (id_q == IDW'(NREQ-1)) ? '0 : id_q + IDW'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // No grant is offered while reset is asserted.
    if (rst) begin
      req_ready = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      id_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
      resp_carry_q  <= 1'b0;
      resp_ovf_q    <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
      resp_carry_q  <= resp_carry_d;
      resp_ovf_q    <= resp_ovf_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign resp_valid    = (state_q == StResp);
  assign resp_id       = resp_id_q;
  assign resp_result   = resp_result_q;
  assign resp_zero     = resp_zero_q;
  assign resp_carry    = resp_carry_q;
  assign resp_overflow = resp_ovf_q;
  assign resp_err      = resp_err_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_control   = op_q;

endmodule

// File: tb/tb_alu_arbitro_rr.sv
// Bench for alu_arbitro_rr: behavioural ALU on the ALU side, scoreboard of expected responses.
module tb_alu_arbitro_rr;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   result;
    logic           zero;
    logic           carry;
    logic           ovf;
    logic           err;
  } resp_t;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*4-1:0] req_op;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_result;
  logic              resp_zero;
  logic              resp_carry;
  logic              resp_overflow;
  logic              resp_err;
  logic [W-1:0]      alu_a;
  logic [W-1:0]      alu_b;
  logic [3:0]        alu_control;
  logic [W-1:0]      alu_resultado;
  logic              alu_zero;
  logic              alu_carry_out;
  logic              alu_overflow;

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  resp_t sb[$];

  alu_arbitro_rr #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_result  (resp_result),
    .resp_zero    (resp_zero),
    .resp_carry   (resp_carry),
    .resp_overflow(resp_overflow),
    .resp_err     (resp_err),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_control  (alu_control),
    .alu_resultado(alu_resultado),
    .alu_zero     (alu_zero),
    .alu_carry_out(alu_carry_out),
    .alu_overflow (alu_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU; unknown opcodes produce junk so a pass-through on illegal ops is visible.
  logic [W:0] sum;
  logic       junk;
  always_comb begin
    sum           = '0;
    junk          = 1'b0;
    alu_resultado = '0;
    alu_carry_out = 1'b0;
    alu_overflow  = 1'b0;
    case (alu_control)
      4'b0000: alu_resultado = alu_a & alu_b;
      4'b0001: alu_resultado = alu_a | alu_b;
      4'b0010: begin
        sum           = {1'b0, alu_a} + {1'b0, alu_b};
        alu_resultado = sum[W-1:0];
        alu_carry_out = sum[W];
        alu_overflow  = (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
      end
      4'b0110: begin
        sum           = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_resultado = sum[W-1:0];
        alu_carry_out = sum[W];
        alu_overflow  = (alu_a[W-1] != alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
      end
      4'b0111: alu_resultado = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b1100: alu_resultado = ~(alu_a | alu_b);
      default: begin
        junk          = 1'b1;
        alu_resultado = 32'hDEADBEEF;
        alu_carry_out = 1'b1;
        alu_overflow  = 1'b1;
      end
    endcase
    alu_zero = junk | (alu_resultado == '0);
  end

  function automatic resp_t observed();
    return {resp_id, resp_result, resp_zero, resp_carry, resp_overflow, resp_err};
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] op);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_op[i*4 +: 4] = op;
  endtask

  task automatic wait_resp(output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      n++;
      ok = (resp_valid === 1'b1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, observed()} !== '0) begin
      failures++;
      $display("FAIL reset_resp got ready=%b valid=%b resp=%h exp all zero",
               req_ready, resp_valid, observed());
    end
    checks++;
    if ({alu_a, alu_b, alu_control} !== '0) begin
      failures++;
      $display("FAIL reset_alu got a=%h b=%h ctl=%b exp 0/0/0000", alu_a, alu_b, alu_control);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== '0 || resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_quiet got ready=%b valid=%b exp 0000/0", req_ready, resp_valid);
      end
    end
  endtask

  task automatic test_single_add();
    resp_t exp;
    @(negedge clk);
    set_req(0, 32'h7FFFFFFF, 32'h1, 4'b0010);
    req_valid  = 4'b0001;
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL add_ready got=%b exp=0001", req_ready);
    end
    sb.push_back({2'd0, 32'h80000000, 4'b0010});
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (resp_valid !== 1'b0 || alu_a !== 32'h7FFFFFFF || alu_b !== 32'h1 || alu_control !== 4'b0010)
    begin
      failures++;
      $display("FAIL add_exec got valid=%b a=%h b=%h ctl=%b exp 0/7fffffff/00000001/0010",
               resp_valid, alu_a, alu_b, alu_control);
    end
    @(negedge clk);
    exp = sb.pop_front();
    checks++;
    if (resp_valid !== 1'b1 || observed() !== exp) begin
      failures++;
      $display("FAIL add_resp got valid=%b resp=%h exp valid=1 resp=%h", resp_valid, observed(), exp);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_back_idle got valid=%b exp=0", resp_valid);
    end
  endtask

  task automatic test_round_robin();
    resp_t exp;
    bit    ok;
    int    n;
    int    last;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 5), 32'd5, 4'b0110);
    req_valid = 4'hF;
    #1;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (req_ready === '0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (req_ready !== 4'(1 << (k % NREQ))) begin
        failures++;
        $display("FAIL rr_grant_%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % NREQ)));
      end
      if (k > 0) begin
        checks++;
        if (cyc - last != 3) begin
          failures++;
          $display("FAIL rr_spacing_%0d got=%0d exp=3", k, cyc - last);
        end
      end
      last = cyc;
      sb.push_back({2'(k % NREQ), 32'(k % NREQ), (k % NREQ) == 0, 1'b1, 1'b0, 1'b0});
      wait_resp(ok);
      exp = sb.pop_front();
      checks++;
      if (!ok || observed() !== exp) begin
        failures++;
        $display("FAIL rr_resp_%0d got valid=%b resp=%h exp=%h", k, ok, observed(), exp);
      end
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    resp_t exp;
    bit    ok;
    @(negedge clk);
    set_req(2, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0000);
    req_valid  = 4'b0100;
    resp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL bp_grant got=%b exp=0100", req_ready);
    end
    sb.push_back({2'd2, 32'hF000F000, 4'b0000});
    @(negedge clk);
    set_req(1, 32'd1, 32'd2, 4'b0010);
    req_valid = 4'b0010;
    @(negedge clk);
    exp = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || observed() !== exp || req_ready !== '0) begin
        failures++;
        $display("FAIL bp_hold_%0d got valid=%b resp=%h ready=%b exp 1/%h/0000",
                 i, resp_valid, observed(), req_ready, exp);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_next_grant got=%b exp=0010", req_ready);
    end
    sb.push_back({2'd1, 32'd3, 4'b0000});
    @(negedge clk);
    req_valid = '0;
    wait_resp(ok);
    exp = sb.pop_front();
    checks++;
    if (!ok || observed() !== exp) begin
      failures++;
      $display("FAIL bp_second_resp got valid=%b resp=%h exp=%h", ok, observed(), exp);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    resp_t exp;
    bit    ok;
    set_req(1, 32'h12345678, 32'h1, 4'b1111);
    req_valid  = 4'b0010;
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL ill_grant got=%b exp=0010", req_ready);
    end
    sb.push_back({2'd1, 32'd0, 4'b0001});
    @(negedge clk);
    req_valid = '0;
    wait_resp(ok);
    exp = sb.pop_front();
    checks++;
    if (!ok || observed() !== exp) begin
      failures++;
      $display("FAIL ill_resp got valid=%b resp=%h exp=%h", ok, observed(), exp);
    end
    @(negedge clk);
    set_req(1, 32'd3, 32'd7, 4'b0111);
    req_valid = 4'b0010;
    #1;
    sb.push_back({2'd1, 32'd1, 4'b0000});
    @(negedge clk);
    req_valid = '0;
    wait_resp(ok);
    exp = sb.pop_front();
    checks++;
    if (!ok || observed() !== exp) begin
      failures++;
      $display("FAIL slt_resp got valid=%b resp=%h exp=%h", ok, observed(), exp);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    resp_t exp;
    bit    ok;
    // ptr is 2 here (last served id 1), so req3 wins before the reset.
    set_req(3, 32'd10, 32'd20, 4'b0010);
    set_req(0, 32'd1, 32'd1, 4'b0010);
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL rm_pre_grant got=%b exp=1000", req_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("FAIL rm_in_reset got valid=%b ready=%b exp 0/0000", resp_valid, req_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rm_grant_after got=%b exp=0001", req_ready);
    end
    sb.push_back({2'd0, 32'd2, 4'b0000});
    @(negedge clk);
    req_valid = '0;
    wait_resp(ok);
    exp = sb.pop_front();
    checks++;
    if (!ok || observed() !== exp) begin
      failures++;
      $display("FAIL rm_resp got valid=%b resp=%h exp=%h", ok, observed(), exp);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL rm_no_stray_%0d got valid=%b id=%0d exp valid=0", i, resp_valid, resp_id);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drained got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
